// File: rtl/program_counter_stack_if.sv
// Command/status bundle for program_counter_stack.
//   master: drives Cp, Ep, Lp, call, ret, pc_in; observes pc, wrap and the
//           stack flags.
//   slave : the counter side.
// The shared tri-state bus Pc_w is a plain net port on the counter. This keeps
// it resolvable against the other drivers on that bus.
interface program_counter_stack_if #(
  parameter int PC_WIDTH = 4
);
  logic                Cp;
  logic                Ep;
  logic                Lp;
  logic                call;
  logic                ret;
  logic [PC_WIDTH-1:0] pc_in;
  logic [PC_WIDTH-1:0] pc;
  logic                wrap;
  logic                stk_full;
  logic                stk_empty;
  logic                stk_err;

  modport master (
    output Cp, Ep, Lp, call, ret, pc_in,
    input  pc, wrap, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  Cp, Ep, Lp, call, ret, pc_in,
    output pc, wrap, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/program_counter_stack.sv
// Program counter with an optional return-address stack.
//   clk    : sole clock, rising edge
//   clr_n  : asynchronous active-low clear
//   bus    : command inputs (Cp, Ep, Lp, call, ret, pc_in) and status
//            outputs (pc, wrap, stk_full, stk_empty, stk_err)
//   Pc_w   : tri-state copy of the PC, driven only while Ep=1
// Build option: define PC_STACK_EN to compile in the return stack.
// Without it, call behaves like Lp, ret is ignored, and the flags are constant.
// Per-edge priority: ret > call > Lp > Cp > hold.
module program_counter_stack #(
  parameter int PC_WIDTH    = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clr_n,
  program_counter_stack_if.slave bus,
  output wire  [PC_WIDTH-1:0]    Pc_w
);
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic                wrap_q, wrap_d;
  // run_q stays low through the first edge after clr_n releases.
  // Commands that coincide with reset release are therefore dropped.
  logic                run_q, run_d;

  assign pc_inc = pc_q + 1'b1;

`ifdef PC_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // Storage is not reset. Once sp_q is zero, stale entries are unreachable.
  logic [PC_WIDTH-1:0] stk_mem [STACK_DEPTH];
  logic [SPW-1:0]      sp_q, sp_d;
  logic                full_q, full_d, empty_q, empty_d, err_q, err_d;
  logic                push;
  logic [AW-1:0]       wr_idx, rd_idx;

  assign wr_idx = AW'(sp_q);
  assign rd_idx = AW'(sp_q - 1'b1);
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.ret, 1'(STACK_DEPTH)};
`endif

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    run_d  = 1'b1;
`ifdef PC_STACK_EN
    sp_d   = sp_q;
    err_d  = err_q;
    push   = 1'b0;
`endif
    if (run_q) begin
`ifdef PC_STACK_EN
      if (bus.ret) begin
        // An underflowing ret changes nothing except the sticky error flag.
        if (empty_q) err_d = 1'b1;
        else begin
          pc_d = stk_mem[rd_idx];
          sp_d = sp_q - 1'b1;
        end
      end else if (bus.call) begin
        // The jump is taken even when the push is refused on overflow.
        pc_d = bus.pc_in;
        if (full_q) err_d = 1'b1;
        else begin
          push = 1'b1;
          sp_d = sp_q + 1'b1;
        end
      end else
`else
      if (bus.call) pc_d = bus.pc_in;
      else
`endif
      if (bus.Lp) pc_d = bus.pc_in;
      else if (bus.Cp) begin
        pc_d   = pc_inc;
        wrap_d = &pc_q;
      end
    end
`ifdef PC_STACK_EN
    full_d  = (sp_d == SPW'(STACK_DEPTH));
    empty_d = (sp_d == '0);
`endif
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_q    <= '0;
      wrap_q  <= 1'b0;
      run_q   <= 1'b0;
`ifdef PC_STACK_EN
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
      run_q   <= run_d;
`ifdef PC_STACK_EN
      sp_q    <= sp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef PC_STACK_EN
  always_ff @(posedge clk) begin
    if (push) stk_mem[wr_idx] <= pc_inc;
  end

  assign bus.stk_full  = full_q;
  assign bus.stk_empty = empty_q;
  assign bus.stk_err   = err_q;
`else
  assign bus.stk_full  = 1'b0;
  assign bus.stk_empty = 1'b1;
  assign bus.stk_err   = 1'b0;
`endif

  assign bus.pc   = pc_q;
  assign bus.wrap = wrap_q;
  assign Pc_w     = bus.Ep ? pc_q : {PC_WIDTH{1'bz}};
endmodule

// File: doc/program_counter_stack.md
PROGRAM_COUNTER_STACK -- requirements
Module: program_counter_stack

Interface
REQ-001 Parameter PC_WIDTH, default 4: width of the program counter, the jump-address input and the bus output; legal range 2..16.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-address entries; legal range 1..16.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 clr_n  input  1  asynchronous active-low reset.
REQ-005 Cp  input  1  count enable: increment the PC.
REQ-006 Ep  input  1  bus enable: drive the PC onto Pc_w.
REQ-007 Lp  input  1  load (jump): PC <= pc_in.
REQ-008 call  input  1  push return address, then jump to pc_in.
REQ-009 ret  input  1  pop the return address into the PC.
REQ-010 pc_in  input  PC_WIDTH  jump/call target address.
REQ-011 Pc_w  output  PC_WIDTH  tri-state bus: the PC when Ep=1, all-Z when Ep=0.
REQ-012 pc  output  PC_WIDTH  PC value, always driven.
REQ-013 wrap  output  1  one-cycle pulse when an increment rolls the PC from all-ones to zero.
REQ-014 stk_full, stk_empty  output  1 each  stack occupancy flags.
REQ-015 stk_err  output  1  sticky flag for stack overflow or underflow.

Function
REQ-016 The command priority per rising edge SHALL be ret > call > Lp > Cp > hold; exactly one command executes per cycle.
REQ-017 Cp alone SHALL set PC <= PC+1 modulo 2^PC_WIDTH.
REQ-018 wrap SHALL be 1 only in the cycle after an increment taken from PC = 2^PC_WIDTH-1; it SHALL be 0 otherwise, including when Lp, call or ret loads zero.
REQ-019 Lp SHALL set PC <= pc_in with no increment; PC+1 is not applied in the same cycle.
REQ-020 call SHALL push (PC+1) mod 2^PC_WIDTH, increment the stack pointer and set PC <= pc_in, all on one edge.
REQ-021 ret SHALL set PC <= the top entry and decrement the stack pointer on one edge.
REQ-022 A call with stk_full=1 SHALL still jump to pc_in, SHALL NOT push or change the stack, and SHALL set stk_err.
REQ-023 A ret with stk_empty=1 SHALL leave PC and the stack unchanged and SHALL set stk_err.
REQ-024 stk_err SHALL clear only on reset.
REQ-025 stk_full SHALL equal (occupancy == STACK_DEPTH) and stk_empty SHALL equal (occupancy == 0); both are registered and valid in the cycle after each push or pop.
REQ-026 Pc_w SHALL track Ep combinationally with no clock latency; Ep SHALL NOT affect any state.
REQ-027 Commands asserted in the same cycle as a reset deassertion edge SHALL be ignored.

Reset
REQ-028 While clr_n=0: PC=0, stack pointer=0, wrap=0, stk_err=0, stk_empty=1, stk_full=0; Pc_w still follows Ep.
REQ-029 Reset SHALL take effect immediately, including mid-operation; stack contents need not be cleared, but they are unreachable after reset.

Configuration
REQ-030 Macro PC_STACK_EN: when defined, the return stack and REQ-020..025 SHALL be compiled in.
REQ-031 When PC_STACK_EN is undefined: no stack storage; call SHALL act as Lp; ret SHALL be ignored; stk_full=0, stk_empty=1 and stk_err=0 SHALL be held constant.

Verification
REQ-032 Reset release, then Cp=1 for 16 cycles (PC_WIDTH=4): pc runs 1..15,0; wrap=1 only in the cycle where pc=0.
REQ-033 PC=3, call with pc_in=9: pc=9 and stack top=4; then ret: pc=4 and stk_empty=1.
REQ-034 STACK_DEPTH=4: five calls to target 2 starting from PC=0: stk_full=1 after the 4th call; the 5th call gives pc=2 and stk_err=1; four rets then return 3,3,3,1.
REQ-035 ret on an empty stack with PC=5: pc stays 5 and stk_err=1; Cp=1, Lp=1, pc_in=7 in one cycle: pc=7 and wrap=0.
REQ-036 Ep toggled 0/1 with PC=6: Pc_w alternates Z/4'b0110; clr_n pulsed low mid-cycle: pc=0 and flags reset with no clock edge.
REQ-037 Build without PC_STACK_EN: call with pc_in=8 gives pc=8; ret gives no change; stk_empty stays 1 and stk_err stays 0.
